// File: rtl/microwave_pkg.sv
// Shared types and key-decode helpers for the microwave keypad path.
package microwave_pkg;

    localparam int BCD_W = 4;
    localparam int KEY_N = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT_RELEASE
    } state_t;

    function automatic logic is_onehot(input logic [KEY_N-1:0] k);
        int n;
        n = 0;
        for (int i = 0; i < KEY_N; i++) begin
            if (k[i]) n++;
        end
        return (n == 1);
    endfunction

    // Lowest set bit wins; only called on snapshots already known to be one-hot.
    function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEY_N-1:0] k);
        logic [BCD_W-1:0] code;
        code = '0;
        for (int i = KEY_N - 1; i >= 0; i--) begin
            if (k[i]) code = BCD_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_settle_counter.sv
// Debounce settle counter shared by the press and release phases.
module settle_counter #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    input  logic start,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // start loads 1 because the sample that triggers it already counts as the first match.
    always_ff @(posedge clk) begin
        if (clear || restart) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad debounce, validation and mm:ss digit entry.
// Optional auto-repeat of a held key is built when KEY_REPEAT_EN is defined.
module keypad_entry_ctrl
    import microwave_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3,
    parameter int MAX_DIGITS    = 4
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 6
`endif
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [9:0]  keys,
    input  logic        clr_entry,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  digit_cnt,
    output logic        busy,
    output logic        error
);

    localparam logic [2:0] MAX_D = 3'(MAX_DIGITS);

    state_t           state;
    logic [KEY_N-1:0] snap;
    logic             tc;
    logic             cnt_restart, cnt_start, cnt_inc;
    logic             settle_fire, rep_fire, fire, accept_ok;

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_settle (
        .clk    (clk),
        .clear  (clear),
        .restart(cnt_restart),
        .start  (cnt_start),
        .inc    (cnt_inc),
        .tc     (tc)
    );

    always_comb begin
        cnt_restart = 1'b0;
        cnt_start   = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (keys != '0) cnt_start = 1'b1;
            end
            SETTLE: begin
                if (keys == '0)        cnt_restart = 1'b1;
                else if (keys != snap) cnt_start   = 1'b1;
                else if (tc)           cnt_restart = 1'b1;
                else                   cnt_inc     = 1'b1;
            end
            WAIT_RELEASE: begin
                if (keys != '0 || tc) cnt_restart = 1'b1;
                else                  cnt_inc     = 1'b1;
            end
            default: cnt_restart = 1'b1;
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_hold;

    assign rep_hold = (state == WAIT_RELEASE) && (keys == snap) && is_onehot(snap);
    assign rep_fire = rep_hold && (rep_cnt == REP_TC);

    always_ff @(posedge clk) begin
        if (clear || !rep_hold || rep_cnt == REP_TC) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign settle_fire = (state == SETTLE) && (keys != '0) && (keys == snap) && tc;
    assign fire        = settle_fire || rep_fire;
    assign accept_ok   = is_onehot(snap) && (digit_cnt < MAX_D);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            snap      <= '0;
            key_valid <= 1'b0;
            error     <= 1'b0;
            key_code  <= '0;
            digits    <= '0;
            digit_cnt <= '0;
        end else begin
            key_valid <= 1'b0;
            error     <= 1'b0;
            case (state)
                IDLE: begin
                    if (keys != '0) begin
                        snap  <= keys;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (keys == '0)        state <= IDLE;
                    else if (keys != snap) snap  <= keys;
                    else if (tc)           state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (keys == '0 && tc) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (fire) begin
                if (accept_ok) begin
                    key_valid <= 1'b1;
                    key_code  <= onehot_to_bcd(snap);
                    digits    <= {digits[11:0], onehot_to_bcd(snap)};
                    digit_cnt <= digit_cnt + 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end
            // Entry clear overrides a same-cycle shift; key_valid/key_code still report it.
            if (clr_entry) begin
                digits    <= '0;
                digit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl.
module tb_keypad_entry_ctrl;

    logic        clk = 1'b0;
    logic        clear;
    logic [9:0]  keys;
    logic        clr_entry;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int ecount = 0;
    int both   = 0;

    always #5 clk = ~clk;

    keypad_entry_ctrl dut (
        .clk      (clk),
        .clear    (clear),
        .keys     (keys),
        .clr_entry(clr_entry),
        .key_valid(key_valid),
        .key_code (key_code),
        .digits   (digits),
        .digit_cnt(digit_cnt),
        .busy     (busy),
        .error    (error)
    );

    always @(negedge clk) begin
        if (key_valid) vcount++;
        if (error) ecount++;
        if (key_valid && error) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [9:0] k);
        keys = k;
        step(4);
        keys = '0;
        step(4);
    endtask

    task automatic zero_counts();
        vcount = 0;
        ecount = 0;
    endtask

    initial begin
        clear     = 1'b1;
        keys      = '0;
        clr_entry = 1'b0;
        step(2);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        clear = 1'b0;
        step(1);

        // Clean press of digit 5 held for 10 samples.
        zero_counts();
        keys = 10'h020;
        step(1);
        chk("t1_busy", 32'(busy), 32'd1);
        step(2);
        chk("t1_early", 32'(key_valid), 32'd0);
        step(1);
        chk("t1_valid", 32'(key_valid), 32'd1);
        chk("t1_code", 32'(key_code), 32'd5);
        chk("t1_digits", 32'(digits), 32'h0005);
        chk("t1_cnt", 32'(digit_cnt), 32'd1);
        step(1);
        chk("t1_pulse_len", 32'(key_valid), 32'd0);
        step(5);
        keys = '0;
        step(4);
        chk("t1_idle", 32'(busy), 32'd0);
`ifdef KEY_REPEAT_EN
        chk("t1_pulses", 32'(vcount), 32'd2);
`else
        chk("t1_pulses", 32'(vcount), 32'd1);
`endif
        clr_entry = 1'b1;
        step(1);
        clr_entry = 1'b0;
        chk("clr_digits", 32'(digits), 32'd0);
        chk("clr_cnt", 32'(digit_cnt), 32'd0);

        // Bouncing press of digit 2.
        zero_counts();
        keys = 10'h004; step(1);
        keys = 10'h000; step(1);
        keys = 10'h004; step(3);
        chk("t2_nopulse", 32'(key_valid), 32'd0);
        step(1);
        chk("t2_valid", 32'(key_valid), 32'd1);
        chk("t2_code", 32'(key_code), 32'd2);
        chk("t2_digits", 32'(digits), 32'h0002);
        keys = '0;
        step(4);
        chk("t2_pulses", 32'(vcount), 32'd1);

        // Two keys at once are rejected.
        zero_counts();
        keys = 10'h006;
        step(4);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_novalid", 32'(key_valid), 32'd0);
        step(2);
        keys = '0;
        step(4);
        chk("t3_errs", 32'(ecount), 32'd1);
        chk("t3_valids", 32'(vcount), 32'd0);
        chk("t3_digits", 32'(digits), 32'h0002);
        chk("t3_both", 32'(both), 32'd0);

        // Fill the entry, then a fifth digit is rejected.
        clr_entry = 1'b1; step(1); clr_entry = 1'b0;
        press(10'h002);
        press(10'h004);
        press(10'h008);
        press(10'h010);
        chk("t4_digits", 32'(digits), 32'h1234);
        chk("t4_cnt", 32'(digit_cnt), 32'd4);
        zero_counts();
        press(10'h080);
        chk("t4_full_err", 32'(ecount), 32'd1);
        chk("t4_full_valid", 32'(vcount), 32'd0);
        chk("t4_full_digits", 32'(digits), 32'h1234);
        chk("t4_full_cnt", 32'(digit_cnt), 32'd4);

        // clear while settling overrides everything.
        keys = 10'h200;
        step(2);
        clear = 1'b1;
        step(1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_digits", 32'(digits), 32'd0);
        chk("t5_cnt", 32'(digit_cnt), 32'd0);
        chk("t5_code", 32'(key_code), 32'd0);
        clear = 1'b0;
        keys  = '0;
        step(1);

        // clr_entry coincident with the accept of 9.
        press(10'h008);
        chk("t6_pre", 32'(digits), 32'h0003);
        keys = 10'h200;
        step(3);
        clr_entry = 1'b1;
        step(1);
        clr_entry = 1'b0;
        chk("t6_valid", 32'(key_valid), 32'd1);
        chk("t6_code", 32'(key_code), 32'd9);
        chk("t6_digits", 32'(digits), 32'd0);
        chk("t6_cnt", 32'(digit_cnt), 32'd0);
        keys = '0;
        step(4);

        // Bounce during release must not re-accept.
        zero_counts();
        keys = 10'h002; step(4);
        keys = 10'h000; step(2);
        keys = 10'h002; step(1);
        keys = 10'h000; step(4);
        chk("t7_pulses", 32'(vcount), 32'd1);
        chk("t7_digits", 32'(digits), 32'h0001);
        chk("t7_idle", 32'(busy), 32'd0);

`ifdef KEY_REPEAT_EN
        clr_entry = 1'b1; step(1); clr_entry = 1'b0;
        zero_counts();
        keys = 10'h002;
        step(16);
        keys = '0;
        step(4);
        chk("t8_repeats", 32'(vcount), 32'd3);
        chk("t8_digits", 32'(digits), 32'h0111);
`endif

        chk("never_both", 32'(both), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
